// File: rtl/aes_pkg.sv
// Shared AES types and constants used by the key schedule and the cipher datapath.
// Round constants are indexed by round number, 1..NR.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int unsigned NR = 10;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
// The same cell is used by the SubBytes stage of the cipher datapath.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Row x holds S(16x+0) .. S(16x+15); entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte x lives at bit offset (255-x)*8, i.e. {~x, 3'b000}.
  assign out_o = SBOX_TBL[{~in_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry
// register file, with a combinational read port indexed by round number.
module aes_key_expand
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  block_t      key_in,
  output logic        busy,
  output logic        done,
  output logic        key_valid,
  input  logic [3:0]  rd_round,
  output block_t      rd_key
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       key_valid_q;
  block_t     rk_q [0:NR];

  block_t     prev_d;
  block_t     next_d;
  logic [7:0] rcon_d;
  word_t      p0_d, p1_d, p2_d, p3_d;
  word_t      rot_d;
  word_t      sub_d;
  word_t      t_d;
  word_t      n0_d, n1_d, n2_d, n3_d;

  // Single round-function datapath, fed from the key written on the previous edge.
  always_comb begin
    prev_d = '0;
    rcon_d = 8'h00;
    if (cnt_q >= 4'd1 && cnt_q <= LAST_RND) begin
      prev_d = rk_q[cnt_q - 4'd1];
      rcon_d = RCON[cnt_q];
    end
  end

  assign p0_d  = prev_d[127:96];
  assign p1_d  = prev_d[95:64];
  assign p2_d  = prev_d[63:32];
  assign p3_d  = prev_d[31:0];
  assign rot_d = {p3_d[23:0], p3_d[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_d[8*b +: 8]),
      .out_o (sub_d[8*b +: 8])
    );
  end

  assign t_d    = sub_d ^ {rcon_d, 24'h000000};
  assign n0_d   = p0_d ^ t_d;
  assign n1_d   = p1_d ^ n0_d;
  assign n2_d   = p2_d ^ n1_d;
  assign n3_d   = p3_d ^ n2_d;
  assign next_d = {n0_d, n1_d, n2_d, n3_d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_valid_q <= 1'b0;
      for (int i = 0; i <= int'(NR); i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            rk_q[0]     <= key_in;
            cnt_q       <= 4'd1;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= EXPAND;
          end
        end
        EXPAND: begin
          rk_q[cnt_q] <= next_d;
          if (cnt_q == LAST_RND) begin
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            key_valid_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = key_valid_q;
  assign rd_key    = (rd_round <= LAST_RND) ? rk_q[rd_round] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: directed FIPS-197 keys plus random keys, checked
// against a word-oriented key-schedule model with an S-box derived from GF(2^8).
module tb_aes_key_expand;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  block_t     key_in;
  logic       busy;
  logic       done;
  logic       key_valid;
  logic [3:0] rd_round;
  block_t     rd_key;

  int tests = 0;
  int fails = 0;

  logic [7:0] sbox_m [256];
  block_t     exp_m [11];

  localparam block_t KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam block_t KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .rd_round  (rd_round),
    .rd_key    (rd_key)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S(x) = affine(inverse(x)), inverse found by search over the field.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Classic 44-word schedule: w[i] = w[i-4] ^ temp.
  task automatic expand_ref(input block_t key);
    word_t      w [44];
    word_t      t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic block_t rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input block_t obs, input block_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_rk(input int r, output block_t v);
    rd_round = 4'(r);
    #1;
    v = rd_key;
  endtask

  task automatic chk_all_rounds(input string tag);
    block_t v;
    for (int r = 0; r < 11; r++) begin
      read_rk(r, v);
      chk($sformatf("%s_rk%0d", tag, r), v, exp_m[r]);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    block_t v;
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_valid"}, 128'(key_valid), 128'(0));
    for (int r = 0; r < 11; r++) begin
      read_rk(r, v);
      chk($sformatf("%s_rk%0d", tag, r), v, '0);
    end
  endtask

  // Issues a one-cycle start; key_in is scrambled right after the sampling edge.
  task automatic do_start(input block_t key);
    key_in = key;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    key_in = rand128();
  endtask

  // Runs 14 edges after the start edge, optionally re-pulsing start before edge extra_at.
  task automatic run_to_done(input string tag, input int extra_at);
    int done_cycle = 0;
    int done_count = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k == extra_at) begin
        start  = 1'b1;
        key_in = rand128();
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (k == 1) begin
        chk({tag, "_busy_t1"}, 128'(busy), 128'(1));
        chk({tag, "_valid_t1"}, 128'(key_valid), 128'(0));
      end
      if (done) begin
        done_count++;
        if (done_cycle == 0) done_cycle = k;
      end
    end
    chk({tag, "_done_cycle"}, 128'(done_cycle), 128'(10));
    chk({tag, "_done_count"}, 128'(done_count), 128'(1));
    chk({tag, "_busy_end"}, 128'(busy), 128'(0));
    chk({tag, "_valid_end"}, 128'(key_valid), 128'(1));
  endtask

  initial begin
    block_t v;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rd_round = 4'd0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // FIPS-197 A.1
    expand_ref(KEY_A1);
    chk("model_a1_rk1", exp_m[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_a1_rk10", exp_m[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_start(KEY_A1);
    run_to_done("a1", 0);
    read_rk(1, v);  chk("a1_rk1_const", v, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk(10, v); chk("a1_rk10_const", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(0, v);  chk("a1_rk0_const", v, KEY_A1);
    chk_all_rounds("a1");

    // FIPS-197 C.1, then key_valid must hold while idle
    expand_ref(KEY_C1);
    do_start(KEY_C1);
    run_to_done("c1", 0);
    read_rk(10, v); chk("c1_rk10_const", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk_all_rounds("c1");
    for (int i = 0; i < 5; i++) begin
      key_in = rand128();
      @(posedge clk);
      #1;
    end
    chk("c1_valid_hold", 128'(key_valid), 128'(1));
    read_rk(10, v); chk("c1_rk10_hold", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // start while busy is ignored
    expand_ref(KEY_A1);
    do_start(KEY_A1);
    run_to_done("busy_start", 4);
    chk_all_rounds("busy_start");

    // asynchronous reset mid-expansion, then a clean restart
    do_start(KEY_A1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    do_start(KEY_A1);
    run_to_done("post_rst", 0);
    chk_all_rounds("post_rst");

    // out-of-range read indices
    for (int r = 11; r < 16; r++) begin
      read_rk(r, v);
      chk($sformatf("oor_rd%0d", r), v, '0);
    end
    read_rk(10, v); chk("oor_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // random keys
    for (int n = 0; n < 4; n++) begin
      block_t k;
      k = rand128();
      expand_ref(k);
      do_start(k);
      run_to_done($sformatf("rnd%0d", n), 0);
      chk_all_rounds($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key schedule feeding the aes_main datapath.
- Loads a 128-bit cipher key, generates round keys 1..10 at one round key per clock, and stores all 11 round keys (0..10) in an internal register file.
- aes_main, or a later round controller, reads any round key by index through a combinational read port.

Parameters:
- NR, 10, number of rounds; fixed for AES-128, and the only value supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to load key_in and expand; sampled only in IDLE.
- key_in  input  128  cipher key; [127:96] = w0, [31:0] = w3; FIPS-197 byte order, MSB byte first.
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when round key 10 has been written.
- key_valid  output  1  level; high while the stored schedule is complete and matches the last loaded key.
- rd_round  input  4  round-key index, 0..10.
- rd_key  output  128  round key for rd_round; combinational from the register file.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0; done=0; key_valid=0; round counter=0; all 11 round-key registers=0; rd_key=0.
- States:
  - IDLE -> EXPAND on start=1. On that edge T: rk[0]<=key_in, counter<=1, key_valid<=0, busy<=1.
  - EXPAND: each edge, rk[counter]<=f(rk[counter-1], RCON[counter]) and counter increments. At the edge where counter==10 is written (T+10): state<=IDLE, busy<=0, done<=1 for exactly one cycle, key_valid<=1.
- Latency: 10 cycles from the start edge to done high. rk[i] is readable from the cycle after edge T+i.
- Round function f(prev) with words p0..p3:
  - t = SubWord(RotWord(p3)) XOR {RCON[i], 24'h0}.
  - n0=p0^t, n1=p1^n0, n2=p2^n1, n3=p3^n2.
  - RotWord rotates left by one byte.
  - RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- start while busy: ignored; no restart, no error flag.
- start in IDLE with key_valid=1: re-expands. key_valid drops on the start edge and returns at done.
- key_in is sampled only on the start edge; later changes have no effect.
- rd_round > 10: rd_key=128'h0.
- rd_round during EXPAND: returns the current register contents; round keys not yet written are either stale or 0. Consumers gate on key_valid.
- Reset mid-expansion: immediate return to reset values; the partial schedule is discarded.
- done and key_valid are registered outputs; busy is registered.

Decomposition:
- Shared package aes_pkg, holding:
  - typedefs word_t (logic [31:0]), block_t (logic [127:0]).
  - localparam NR=10.
  - RCON constant array [1:10].
  - state enum {IDLE, EXPAND}.
- Sub-module aes_sbox: combinational 8-bit S-box, the same cell used by aes_main's SubBytes. Four instances form SubWord.
- Only one round-function datapath instance; it is reused every cycle.

Test Plan:
- Reset: assert rst mid-simulation -> busy=0, done=0, key_valid=0, rd_key=0 for every rd_round 0..10.
- FIPS-197 A.1 key:
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c with one-cycle start.
  - done exactly 10 cycles later.
  - rd_round=1 -> a0fafe1788542cb123a339392a6c7605.
  - rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rd_round=0 -> the original key.
- FIPS-197 C.1 key:
  - Stimulus: key_in=000102030405060708090a0b0c0d0e0f.
  - rd_round=10 -> 13111d7fe3944a17f307a78b4d2b30c5 after done.
  - key_valid stays 1 until the next start.
- start during busy:
  - Stimulus: pulse start with a different key_in at cycle T+4.
  - Required: ignored; the schedule completes for the original key with the same A.1 values; done pulses once at T+10.
- Reset mid-operation: assert rst at T+5 -> all outputs at reset values immediately (async); a new start after reset produces the correct A.1 schedule.
- Out-of-range read: after completion, rd_round=11..15 -> rd_key=0; rd_round=10 is still correct.
